// File: rtl/parpadeo_pkg.sv
// Shared encodings for the cursor blink timer: FSM state codes and run-mode constants.
package parpadeo_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {
    EST_IDLE = S_IDLE,
    EST_ON   = S_ON,
    EST_OFF  = S_OFF
  } estado_t;

endpackage

// File: rtl/contador_fase.sv
// Phase counter for the blink timer: synchronous clear, count enable and a
// terminal flag raised when the count sits one below the supplied limit.
module contador_fase #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cont,
  output logic             term
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cont_r;

  // Count register: clear has priority over enable, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      cont_r <= {WIDTH{1'b0}};
    end else if (en) begin
      cont_r <= cont_r + ONE;
    end else begin
      cont_r <= cont_r;
    end
  end

  // limit is never zero when term is consumed, so limit-1 cannot underflow.
  assign cont = cont_r;
  assign term = (cont_r == (limit - ONE));

endmodule

// File: rtl/temporizador_parpadeo.sv
// Cursor blink timer: programmable ON then OFF phase, CB pulse at each period end.
// Optional BLINK_PAUSE_EN adds a 'pause' input that freezes an active run.
module temporizador_parpadeo
  import parpadeo_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int DEF_PERIODIC = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             stop,
  input  logic             mode,
  input  logic             mode_valid,
`ifdef BLINK_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] period_on,
  input  logic [WIDTH-1:0] period_off,
  output logic             blink,
  output logic             CB,
  output logic             busy,
  output logic [WIDTH-1:0] cont
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic DEF_MODE = (DEF_PERIODIC != 0) ? MODE_PERIODIC : MODE_ONESHOT;

  estado_t          state_r, state_nx_s, eop_state_s;
  logic [WIDTH-1:0] lat_on_r, lat_off_r, on_eff_s, limit_s;
  logic             lat_mode_r, mode_eff_s, per_s;
  logic             blink_r, cb_r, busy_r, cb_nx_s;
  logic             cnt_clr_s, cnt_en_s, term_s, pause_s;
  logic             latch_per_s, latch_mode_s;

`ifdef BLINK_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // A zero ON length still gives one visible cycle.
  assign on_eff_s    = (lat_on_r == ZERO) ? ONE : lat_on_r;
  assign limit_s     = (state_r == EST_OFF) ? lat_off_r : on_eff_s;
  assign mode_eff_s  = mode_valid ? mode : DEF_MODE;
  assign per_s       = (lat_mode_r == MODE_PERIODIC);
  assign eop_state_s = per_s ? EST_ON : EST_IDLE;

  contador_fase #(.WIDTH(WIDTH)) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .limit (limit_s),
    .cont  (cont),
    .term  (term_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and datapath controls; stop outranks pause, pause outranks counting.
  always_comb begin
    state_nx_s   = state_r;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    latch_per_s  = 1'b0;
    latch_mode_s = 1'b0;
    cb_nx_s      = 1'b0;
    case (state_r)
      EST_IDLE: begin
        cnt_clr_s = 1'b1;
        if (init && !stop) begin
          state_nx_s   = EST_ON;
          latch_per_s  = 1'b1;
          latch_mode_s = 1'b1;
        end else begin
          state_nx_s = EST_IDLE;
        end
      end
      EST_ON: begin
        if (stop) begin
          state_nx_s = EST_IDLE;
          cnt_clr_s  = 1'b1;
        end else if (pause_s) begin
          cb_nx_s = cb_r;
        end else if (term_s && (lat_off_r == ZERO)) begin
          state_nx_s  = eop_state_s;
          latch_per_s = per_s;
          cnt_clr_s   = 1'b1;
          cb_nx_s     = 1'b1;
        end else if (term_s) begin
          state_nx_s = EST_OFF;
          cnt_clr_s  = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      EST_OFF: begin
        if (stop) begin
          state_nx_s = EST_IDLE;
          cnt_clr_s  = 1'b1;
        end else if (pause_s) begin
          cb_nx_s = cb_r;
        end else if (term_s) begin
          state_nx_s  = eop_state_s;
          latch_per_s = per_s;
          cnt_clr_s   = 1'b1;
          cb_nx_s     = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = EST_IDLE;
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  // Period and mode latches; periods refresh at start and at each periodic boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_on_r   <= ZERO;
      lat_off_r  <= ZERO;
      lat_mode_r <= MODE_ONESHOT;
    end else begin
      if (latch_per_s) begin
        lat_on_r  <= period_on;
        lat_off_r <= period_off;
      end
      if (latch_mode_s) begin
        lat_mode_r <= mode_eff_s;
      end
    end
  end

  // Registered outputs derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_r <= 1'b0;
      busy_r  <= 1'b0;
      cb_r    <= 1'b0;
    end else begin
      blink_r <= (state_nx_s == EST_ON);
      busy_r  <= (state_nx_s != EST_IDLE);
      cb_r    <= cb_nx_s;
    end
  end

  assign blink = blink_r;
  assign busy  = busy_r;
  assign CB    = cb_r;

endmodule

// File: tb/tb_temporizador_parpadeo.sv
// Self-checking bench for temporizador_parpadeo; reference model tracks the
// position inside the current period. Honours BLINK_PAUSE_EN when defined.
module tb_temporizador_parpadeo;

  localparam int W    = 4;
  localparam int DEFP = 0;

  logic         clk = 1'b0;
  logic         rst, init, stop, mode, mode_valid;
`ifdef BLINK_PAUSE_EN
  logic         pause;
`endif
  logic [W-1:0] period_on, period_off;
  logic         blink, CB, busy;
  logic [W-1:0] cont;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: active flag, cycles into current period, latched lengths.
  bit m_busy, m_per, m_cb;
  int m_pos, m_A, m_B;

  temporizador_parpadeo #(.WIDTH(W), .DEF_PERIODIC(DEFP)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .stop       (stop),
    .mode       (mode),
    .mode_valid (mode_valid),
`ifdef BLINK_PAUSE_EN
    .pause      (pause),
`endif
    .period_on  (period_on),
    .period_off (period_off),
    .blink      (blink),
    .CB         (CB),
    .busy       (busy),
    .cont       (cont)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0; m_per = 1'b0; m_cb = 1'b0; m_pos = 0; m_A = 0; m_B = 0;
    end else if (!m_busy) begin
      m_cb = 1'b0;
      if (init && !stop) begin
        m_busy = 1'b1; m_pos = 0;
        m_A = (period_on == '0) ? 1 : int'(period_on);
        m_B = int'(period_off);
        m_per = mode_valid ? mode : (DEFP != 0);
      end
    end else if (stop) begin
      m_busy = 1'b0; m_pos = 0; m_cb = 1'b0;
    end
`ifdef BLINK_PAUSE_EN
    else if (pause) begin
      m_pos = m_pos;
    end
`endif
    else begin
      m_cb  = 1'b0;
      m_pos = m_pos + 1;
      if (m_pos == m_A + m_B) begin
        m_cb  = 1'b1;
        m_pos = 0;
        if (m_per) begin
          m_A = (period_on == '0) ? 1 : int'(period_on);
          m_B = int'(period_off);
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [W+2:0] m_vec();
    logic [W-1:0] c;
    logic         bl;
    if (!m_busy) begin
      c = '0; bl = 1'b0;
    end else if (m_pos < m_A) begin
      c = W'(m_pos); bl = 1'b1;
    end else begin
      c = W'(m_pos - m_A); bl = 1'b0;
    end
    return {m_busy, bl, m_cb, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic quiet_inputs();
    init = 1'b0; stop = 1'b0; mode = 1'b0; mode_valid = 1'b0;
`ifdef BLINK_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1; period_on = '0; period_off = '0;
    tick(); tick();
    checks++;
    if ({busy, blink, CB, cont} !== '0) begin
      failures++; $display("FAIL reset_state got=%b exp=0", {busy, blink, CB, cont});
    end
    rst = 1'b0; tick();
    period_on = W'(6); period_off = W'(2); mode_valid = 1'b1; mode = 1'b1; init = 1'b1;
    tick(); init = 1'b0;
    for (int i = 0; i < 20 && !(blink === 1'b1 && cont === W'(3)); i++) tick();
    checks++;
    if (!(blink === 1'b1 && cont === W'(3))) begin
      failures++; $display("FAIL reset_reach_on3 got blink=%b cont=%0d exp blink=1 cont=3", blink, cont);
    end
    #2 rst = 1'b1;
    #1 model_step();
    checks++;
    if ({busy, blink, CB, cont} !== '0) begin
      failures++; $display("FAIL reset_async got=%b exp=0", {busy, blink, CB, cont});
    end
    tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({busy, blink, CB, cont} !== '0 || m_vec() !== '0) begin
        failures++; $display("FAIL reset_stays_idle cyc=%0d got=%b exp=0", cyc, {busy, blink, CB, cont});
      end
    end
  endtask

  task automatic test_oneshot();
    int cb_at, on_cnt, exp_at;
    for (int r = 0; r < 7; r++) begin
      quiet_inputs();
      if (r == 0) begin
        period_on = W'(4); period_off = W'(3); mode_valid = 1'b1; mode = 1'b0;
      end else begin
        period_on  = W'($urandom_range(0, 15));
        period_off = W'($urandom_range(0, 15));
        mode_valid = 1'($urandom_range(0, 1));
        mode       = 1'b0;
      end
      exp_at = ((period_on == '0) ? 1 : int'(period_on)) + int'(period_off) + 1;
      init = 1'b1; tick(); init = 1'b0;
      cb_at = -1; on_cnt = 0;
      for (int k = 1; k <= 36; k++) begin
        checks++;
        if ({busy, blink, CB, cont} !== m_vec()) begin
          failures++; $display("FAIL oneshot_model r=%0d k=%0d got=%b exp=%b", r, k, {busy, blink, CB, cont}, m_vec());
        end
        if (blink === 1'b1) on_cnt++;
        if (CB === 1'b1 && cb_at < 0) cb_at = k;
        period_on = W'($urandom_range(0, 15));
        tick();
      end
      checks++;
      if (cb_at != exp_at) begin
        failures++; $display("FAIL oneshot_cb_time r=%0d got=%0d exp=%0d", r, cb_at, exp_at);
      end
      if (r == 0) begin
        checks++;
        if (on_cnt != 4) begin
          failures++; $display("FAIL oneshot_on_len got=%0d exp=4", on_cnt);
        end
      end
    end
  endtask

  task automatic test_periodic_live();
    int t[$];
    quiet_inputs();
    period_on = W'(2); period_off = W'(2); mode_valid = 1'b1; mode = 1'b1;
    init = 1'b1; tick(); init = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      checks++;
      if ({busy, blink, CB, cont} !== m_vec()) begin
        failures++; $display("FAIL periodic_model k=%0d got=%b exp=%b", k, {busy, blink, CB, cont}, m_vec());
      end
      if (CB === 1'b1) t.push_back(k);
      if (t.size() == 2) period_on = W'(5);
      tick();
    end
    checks++;
    if (t.size() < 5 || t[0] != 5 || t[1] - t[0] != 4 || t[2] - t[1] != 4 ||
        t[3] - t[2] != 7 || t[4] - t[3] != 7) begin
      failures++; $display("FAIL periodic_spacing got n=%0d first=%0d exp first=5 gaps 4,4,7,7", t.size(), (t.size() > 0) ? t[0] : -1);
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_boundaries();
    int on_cnt, max_c;
    quiet_inputs();
    period_on = '0; period_off = '0; mode_valid = 1'b1; mode = 1'b1;
    init = 1'b1; tick(); init = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (blink !== 1'b1 || CB !== (k >= 2) || cont !== '0) begin
        failures++; $display("FAIL bound_zero k=%0d got blink=%b CB=%b cont=%0d exp blink=1 CB=%0d cont=0", k, blink, CB, cont, (k >= 2));
      end
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    period_on = W'(15); period_off = W'(1); mode = 1'b0;
    init = 1'b1; tick(); init = 1'b0;
    on_cnt = 0; max_c = 0;
    for (int k = 1; k <= 20; k++) begin
      checks++;
      if ({busy, blink, CB, cont} !== m_vec()) begin
        failures++; $display("FAIL bound_max_model k=%0d got=%b exp=%b", k, {busy, blink, CB, cont}, m_vec());
      end
      if (blink === 1'b1) begin
        on_cnt++;
        if (int'(cont) > max_c) max_c = int'(cont);
      end
      tick();
    end
    checks++;
    if (on_cnt != 15 || max_c != 14) begin
      failures++; $display("FAIL bound_max_on got len=%0d peak=%0d exp len=15 peak=14", on_cnt, max_c);
    end
  endtask

  task automatic test_stop_init();
    int cb_at;
    quiet_inputs();
    period_on = W'(3); period_off = W'(4); mode_valid = 1'b1; mode = 1'b1;
    init = 1'b1; tick(); init = 1'b0;
    for (int i = 0; i < 20 && !(busy === 1'b1 && blink === 1'b0 && cont === W'(1)); i++) tick();
    checks++;
    if (!(busy === 1'b1 && blink === 1'b0 && cont === W'(1))) begin
      failures++; $display("FAIL stop_reach_off1 got busy=%b blink=%b cont=%0d exp 1 0 1", busy, blink, cont);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({busy, blink, CB, cont} !== '0) begin
        failures++; $display("FAIL stop_in_off k=%0d got=%b exp=0", k, {busy, blink, CB, cont});
      end
      tick();
    end
    init = 1'b1; stop = 1'b1; tick(); init = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, blink, CB, cont} !== '0) begin
      failures++; $display("FAIL init_stop_idle got=%b exp=0", {busy, blink, CB, cont});
    end
    period_on = W'(3); period_off = W'(3); mode = 1'b0;
    init = 1'b1; tick();
    period_on = W'(9); period_off = W'(9);
    cb_at = -1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) init = 1'b0;
      checks++;
      if ({busy, blink, CB, cont} !== m_vec()) begin
        failures++; $display("FAIL init_busy_model k=%0d got=%b exp=%b", k, {busy, blink, CB, cont}, m_vec());
      end
      if (CB === 1'b1 && cb_at < 0) cb_at = k;
      tick();
    end
    checks++;
    if (cb_at != 7) begin
      failures++; $display("FAIL init_busy_ignored got cb=%0d exp=7", cb_at);
    end
  endtask

`ifdef BLINK_PAUSE_EN
  task automatic test_pause();
    int cb_at;
    quiet_inputs();
    period_on = W'(6); period_off = W'(2); mode_valid = 1'b1; mode = 1'b0;
    init = 1'b1; tick(); init = 1'b0;
    cb_at = -1;
    for (int k = 1; k <= 24; k++) begin
      checks++;
      if ({busy, blink, CB, cont} !== m_vec()) begin
        failures++; $display("FAIL pause_model k=%0d got=%b exp=%b", k, {busy, blink, CB, cont}, m_vec());
      end
      if (k >= 4 && k <= 8) begin
        checks++;
        if (cont !== W'(2) || blink !== 1'b1) begin
          failures++; $display("FAIL pause_hold k=%0d got cont=%0d blink=%b exp 2 1", k, cont, blink);
        end
      end
      if (CB === 1'b1 && cb_at < 0) cb_at = k;
      pause = (k >= 3 && k <= 7);
      tick();
    end
    pause = 1'b0;
    checks++;
    if (cb_at != 14) begin
      failures++; $display("FAIL pause_cb_delay got=%0d exp=14", cb_at);
    end
  endtask
`endif

  task automatic test_random();
    quiet_inputs();
    for (int k = 0; k < 1500; k++) begin
      init       = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 29) == 0);
      mode       = 1'($urandom_range(0, 1));
      mode_valid = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 299) == 0);
`ifdef BLINK_PAUSE_EN
      pause      = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 3) == 0) begin
        period_on  = W'($urandom_range(0, 15));
        period_off = W'($urandom_range(0, 15));
      end
      tick();
      checks++;
      if ({busy, blink, CB, cont} !== m_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {busy, blink, CB, cont}, m_vec());
      end
    end
    rst = 1'b0;
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_live();
    test_boundaries();
    test_stop_init();
`ifdef BLINK_PAUSE_EN
    stop = 1'b1; tick(); stop = 1'b0;
    test_pause();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temporizador_parpadeo.md
Name: temporizador_parpadeo

Overview:
- Parametrised successor to the single-threshold white-count block; generates the cursor blink timing for the paint core.
- Runs a programmable ON phase followed by a programmable OFF phase.
- Pulses CB at the end of each full period, in one-shot or periodic mode.
- Sits beside the cursor/paint control FSM, which consumes `blink` (cursor visible) and `CB` (period complete).

Parameters:
- WIDTH, 24, width of the phase counter and of the period inputs.
- DEF_PERIODIC, 0, mode used when `mode_valid` is low at start (0 = one-shot, 1 = periodic).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- init  input  1  start request; sampled in IDLE only.
- stop  input  1  abort; highest priority after reset.
- mode  input  1  0 = one-shot, 1 = periodic.
- mode_valid  input  1  when high at start, `mode` is used; otherwise DEF_PERIODIC.
- period_on  input  WIDTH  ON-phase length in cycles.
- period_off  input  WIDTH  OFF-phase length in cycles.
- blink  output  1  high during the ON phase.
- CB  output  1  one-cycle pulse at the end of each full period.
- busy  output  1  high whenever state is not IDLE.
- cont  output  WIDTH  current phase count.

Behaviour:
- Reset (async, any state): state=IDLE; cont=0; blink=0; CB=0; busy=0; latched periods=0; latched mode=0.
- All outputs are registered.
- States: IDLE, ON, OFF.
- IDLE:
  - init=1 and stop=0 → latch period_on, period_off and the effective mode; cont←0; next state ON.
  - blink and busy rise in the cycle after init is sampled (latency 1).
- ON:
  - blink=1; cont increments by 1 per cycle.
  - When cont == lat_on−1: cont←0; go to OFF.
  - If lat_off==0, OFF is skipped and the end-of-period action runs immediately.
  - lat_on==0 is treated as 1 (minimum one ON cycle).
- OFF:
  - blink=0; cont increments by 1 per cycle.
  - When cont == lat_off−1, the end-of-period action runs.
- End of period:
  - CB=1 in the next cycle, for exactly one cycle.
  - Periodic: re-latch period_on/period_off from the inputs and return to ON with cont=0. This allows live rate changes at period boundaries only.
  - One-shot: go to IDLE; busy falls in the same cycle CB is high.
- stop=1 in ON or OFF: next state IDLE, cont=0, blink=0, no CB. stop in IDLE has no effect.
- init while busy is ignored; no queueing.
- Simultaneous init and stop in IDLE: stop wins and the block stays IDLE.
- cont never wraps: the terminal compare happens at or below 2^WIDTH−2. The maximum phase is 2^WIDTH−1 cycles.
- Changes to period/mode inputs mid-phase have no effect until the next latch point.
- Full period length = max(lat_on,1) + lat_off cycles between consecutive CB pulses in periodic mode.

Optional Feature:
- Macro: BLINK_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in ON/OFF: cont, state, blink and the CB pipeline hold their values.
  - stop and rst still act during pause.
  - pause in IDLE has no effect, and init is still accepted.
- Undefined: no `pause` port; counting is never frozen.

Decomposition:
- Shared package `parpadeo_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_ON=2'd1, S_OFF=2'd2;
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One sub-module, `contador_fase`: WIDTH-bit counter with synchronous clear, enable, async rst, and a terminal-compare output (cont == limit−1).
- The top-level module holds the FSM, the latches and the CB register.

Test Plan:
- Reset mid-run: rst asserted in ON at cont=3 → all outputs 0 the same cycle; IDLE after release; init is needed to restart.
- One-shot: on=4, off=3, mode_valid=1, mode=0, init pulse at T → blink=1 over T+1..T+4, 0 over T+5..T+7; CB=1 only at T+8; busy=0 from T+8.
- Periodic with live update: on=2, off=2, periodic → CB every 4 cycles. Change on=5 mid-period → new ON length is 5 only after the next CB; CB spacing becomes 7.
- Boundaries:
  - on=0, off=0 → 1-cycle ON, CB every cycle in periodic mode.
  - on=2^WIDTH−1 with WIDTH=4 → ON lasts 15 cycles; cont peaks at 14 and never wraps.
- stop/init priority:
  - stop at OFF cont=1 → IDLE next cycle, no CB.
  - init+stop simultaneous in IDLE → stays IDLE.
  - init during busy → ignored.
- With BLINK_PAUSE_EN: pause held 5 cycles in ON at cont=2 → cont stays 2 and blink stays 1; CB arrives 5 cycles later than without pause.
